// File: rtl/a2d_pkg.sv
// Shared types and frame geometry for the A2D SPI responder.
package a2d_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int CH_MSB     = 13;
  localparam int CH_LSB     = 11;
  localparam int DATA_W     = 12;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for one SPI pin, plus rise/fall detection on the synchronized level.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values for the synchronizer chain and the one-cycle-old copy used for edge detect
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Chain flops reset to the pin's idle level so no false edge appears after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI (mode 0) slave that emulates an A2D converter: answers each frame with the
// table entry of the channel commanded in the previous frame.
module a2d_spi_resp
  import a2d_pkg::*;
#(
  parameter logic [11:0] RST_VAL  = 12'h800,
  parameter int          MIN_HALF = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        wr_en,
  input  logic [2:0]  wr_chnnl,
  input  logic [11:0] wr_data,
  output logic [2:0]  chnnl_cmd,
  output logic        trans_done,
  output logic        frame_err
);

  // The synchronizers add 3 cycles of latency, so shorter SCLK half-periods are meaningless
  if (MIN_HALF < 3) begin : g_min_half_check
    $error("a2d_spi_resp: MIN_HALF must be at least 3");
  end

  logic ss_rise, ss_fall;
  logic sclk_rise, sclk_fall;

  spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SS_n),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  logic mosi_meta_q, mosi_meta_d;
  logic mosi_sync_q, mosi_sync_d;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [2:0]              chnnl_cmd_q, chnnl_cmd_d;
  logic                    trans_done_q, trans_done_d;
  logic                    frame_err_q, frame_err_d;
  logic [DATA_W-1:0]       tbl_q [8];
  logic [DATA_W-1:0]       tbl_d [8];

  // Frame FSM, shifters, channel latch and channel table next-state logic
  always_comb begin
    mosi_meta_d  = MOSI;
    mosi_sync_d  = mosi_meta_q;
    state_d      = state_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    cnt_d        = cnt_q;
    chnnl_cmd_d  = chnnl_cmd_q;
    trans_done_d = 1'b0;
    frame_err_d  = 1'b0;
    tbl_d        = tbl_q;
    if (wr_en) begin
      tbl_d[wr_chnnl] = wr_data;
    end
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = SHIFT;
          tx_d    = {{(FRAME_BITS - DATA_W){1'b0}}, tbl_d[chnnl_cmd_q]};
          cnt_d   = 5'd0;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (cnt_q == 5'(FRAME_BITS)) begin
            chnnl_cmd_d  = rx_q[CH_MSB:CH_LSB];
            trans_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_d = {rx_q[FRAME_BITS-2:0], mosi_sync_q};
          if (cnt_q != 5'd31) begin
            cnt_d = cnt_q + 5'd1;
          end
        end else if (sclk_fall && (cnt_q != 5'd0)) begin
          tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All block state, cleared to idle with every table entry at its reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta_q  <= 1'b0;
      mosi_sync_q  <= 1'b0;
      state_q      <= IDLE;
      rx_q         <= '0;
      tx_q         <= '0;
      cnt_q        <= 5'd0;
      chnnl_cmd_q  <= 3'b000;
      trans_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        tbl_q[i] <= RST_VAL;
      end
    end else begin
      mosi_meta_q  <= mosi_meta_d;
      mosi_sync_q  <= mosi_sync_d;
      state_q      <= state_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      cnt_q        <= cnt_d;
      chnnl_cmd_q  <= chnnl_cmd_d;
      trans_done_q <= trans_done_d;
      frame_err_q  <= frame_err_d;
      for (int i = 0; i < 8; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  assign MISO       = (state_q == SHIFT) ? tx_q[FRAME_BITS-1] : 1'b0;
  assign chnnl_cmd  = chnnl_cmd_q;
  assign trans_done = trans_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Self-checking bench for a2d_spi_resp: drives SPI frames as the A2D master and
// compares each response word against a queue of expected words from a table model.
module tb_a2d_spi_resp;

  localparam int HALF = 16;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        SS_n     = 1'b1;
  logic        SCLK     = 1'b0;
  logic        MOSI     = 1'b0;
  logic        wr_en    = 1'b0;
  logic [2:0]  wr_chnnl = 3'd0;
  logic [11:0] wr_data  = 12'd0;
  logic        MISO;
  logic [2:0]  chnnl_cmd;
  logic        trans_done;
  logic        frame_err;

  int testCount = 0;
  int failCount = 0;
  int tdCount   = 0;
  int feCount   = 0;

  logic [11:0] tbTbl [8];
  logic [2:0]  tbCh;
  logic [15:0] expQ [$];

  a2d_spi_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .wr_en     (wr_en),
    .wr_chnnl  (wr_chnnl),
    .wr_data   (wr_data),
    .chnnl_cmd (chnnl_cmd),
    .trans_done(trans_done),
    .frame_err (frame_err)
  );

  // 50 MHz system clock
  always #10 clk = ~clk;

  // Count completion and error pulses away from the active edge
  always @(negedge clk) begin
    if (trans_done) tdCount++;
    if (frame_err) feCount++;
  end

  // Hard time limit so the run can never hang
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic resetModel();
    for (int i = 0; i < 8; i++) tbTbl[i] = 12'h800;
    tbCh = 3'd0;
  endtask

  task automatic writeTable(input logic [2:0] ch, input logic [11:0] data);
    @(negedge clk);
    wr_en    = 1'b1;
    wr_chnnl = ch;
    wr_data  = data;
    @(negedge clk);
    wr_en = 1'b0;
    tbTbl[ch] = data;
  endtask

  // One SPI frame of nbits; optionally writes the table after bit 7 of the frame
  task automatic applyStimulus(input logic [15:0] cmd, input int nbits, input bit midWr,
                               input logic [2:0] wrCh, input logic [11:0] wrVal);
    logic [15:0] got;
    logic [15:0] expWord;
    int td0;
    int fe0;
    if (nbits == 16) expQ.push_back({4'b0000, tbTbl[tbCh]});
    td0 = tdCount;
    fe0 = feCount;
    got = 16'h0000;
    @(negedge clk);
    SS_n = 1'b0;
    waitClk(HALF);
    for (int i = 0; i < nbits; i++) begin
      MOSI = cmd[15 - (i % 16)];
      waitClk(HALF);
      SCLK = 1'b1;
      got  = {got[14:0], MISO};
      waitClk(HALF);
      SCLK = 1'b0;
      if (midWr && i == 7) writeTable(wrCh, wrVal);
    end
    waitClk(HALF);
    SS_n = 1'b1;
    waitClk(10);
    if (nbits == 16) begin
      tbCh = cmd[13:11];
      checkOutput("trans_done_pulses", tdCount - td0, 1);
      checkOutput("frame_err_pulses", feCount - fe0, 0);
      checkOutput("chnnl_cmd", {29'd0, chnnl_cmd}, {29'd0, tbCh});
      expWord = expQ.pop_front();
      checkOutput("miso_word", {16'd0, got}, {16'd0, expWord});
    end else begin
      checkOutput("short_trans_done_pulses", tdCount - td0, 0);
      checkOutput("short_frame_err_pulses", feCount - fe0, 1);
      checkOutput("short_chnnl_hold", {29'd0, chnnl_cmd}, {29'd0, tbCh});
    end
  endtask

  initial begin
    int td0;
    int fe0;
    resetModel();
    waitClk(5);
    checkOutput("reset_miso", {31'd0, MISO}, 0);
    checkOutput("reset_chnnl", {29'd0, chnnl_cmd}, 0);
    checkOutput("reset_trans_done", {31'd0, trans_done}, 0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    waitClk(5);

    // Default table contents returned on the very first frame
    applyStimulus(16'h0000, 16, 1'b0, 3'd0, 12'd0);

    // Channel 5 write, then two frames commanding channel 5
    writeTable(3'd5, 12'hABC);
    applyStimulus(16'h2800, 16, 1'b0, 3'd0, 12'd0);
    applyStimulus(16'h2800, 16, 1'b0, 3'd0, 12'd0);

    // Fill all channels, then a pair of frames per channel
    for (int n = 0; n < 8; n++) writeTable(3'(n), 12'(n * 12'h101));
    for (int n = 0; n < 8; n++) begin
      applyStimulus({2'b00, 3'(n), 11'd0}, 16, 1'b0, 3'd0, 12'd0);
      applyStimulus({2'b00, 3'(n), 11'd0}, 16, 1'b0, 3'd0, 12'd0);
    end

    // Short frame and an over-long frame that would alias to 16 if the counter wrapped
    applyStimulus(16'h3800, 9, 1'b0, 3'd0, 12'd0);
    applyStimulus(16'h3800, 48, 1'b0, 3'd0, 12'd0);

    // Mid-frame write to the latched channel only affects the following frame
    applyStimulus(16'h1800, 16, 1'b0, 3'd0, 12'd0);
    applyStimulus(16'h1800, 16, 1'b1, 3'd3, 12'h5A5);
    applyStimulus(16'h1800, 16, 1'b0, 3'd0, 12'd0);

    // Reset after bit 7 of a frame abandons it silently
    td0 = tdCount;
    fe0 = feCount;
    @(negedge clk);
    SS_n = 1'b0;
    waitClk(HALF);
    for (int i = 0; i < 8; i++) begin
      MOSI = 1'b1;
      waitClk(HALF);
      SCLK = 1'b1;
      waitClk(HALF);
      SCLK = 1'b0;
    end
    waitClk(4);
    rst_n = 1'b0;
    waitClk(2);
    checkOutput("midreset_miso", {31'd0, MISO}, 0);
    checkOutput("midreset_chnnl", {29'd0, chnnl_cmd}, 0);
    SS_n = 1'b1;
    MOSI = 1'b0;
    waitClk(4);
    rst_n = 1'b1;
    waitClk(10);
    checkOutput("midreset_trans_done", tdCount - td0, 0);
    checkOutput("midreset_frame_err", feCount - fe0, 0);
    resetModel();

    // Full frames after reset see the restored table
    applyStimulus(16'h1800, 16, 1'b0, 3'd0, 12'd0);
    applyStimulus(16'h0000, 16, 1'b0, 3'd0, 12'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
